fifo2axis_mc: RTL and testbench



---
 rtl/fifo2axis_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_fifo2axis_mc.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2axis_mc.sv
// fifo2axis_mc: multi-channel FIFO to AXI-Stream bridge.
// Drains N_CH one-cycle-latency FIFOs into one AXIS master, one frame at a
// time, with round-robin arbitration between frames and a 2-entry skid buffer
// so the stream sustains one word per cycle under backpressure.
// Stream handshake: a word transfers on every cycle where axis_tvalid_o and
// axis_tready_i are both high; once axis_tvalid_o is high, tdata/tdest/tlast
// stay stable until that transfer happens.
// Optional build macro FIFO2AXIS_MC_FRAME_CNT_EN adds frame_cnt_o, a 16-bit
// per-channel count of completed frames.
module fifo2axis_mc #(
    parameter int N_CH       = 2,
    parameter int DATA_W     = 32,
    parameter int AXIS_LEN_W = 8,
    parameter int TDEST_W    = 1
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         cke_i,
    input  logic                         en_i,
    input  logic [N_CH*AXIS_LEN_W-1:0]   len_i,
    input  logic [N_CH-1:0]              fifo_empty_i,
    output logic [N_CH-1:0]              fifo_read_o,
    input  logic [N_CH*DATA_W-1:0]       fifo_rdata_i,
    output logic                         axis_tvalid_o,
    output logic [DATA_W-1:0]            axis_tdata_o,
    output logic [TDEST_W-1:0]           axis_tdest_o,
    output logic                         axis_tlast_o,
    input  logic                         axis_tready_i,
    output logic                         busy_o
`ifdef FIFO2AXIS_MC_FRAME_CNT_EN
    ,
    output logic [N_CH*16-1:0]           frame_cnt_o
`endif
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ENT_W = DATA_W + TDEST_W + 1;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [AXIS_LEN_W-1:0] LEN_ONE = AXIS_LEN_W'(1);

    // Frame sequencing state
    logic [0:0]            state;
    logic [CH_W-1:0]       ptr;       // channel served last; search starts after it
    logic [CH_W-1:0]       cur_ch;    // channel of the open frame
    logic [AXIS_LEN_W-1:0] rem;       // reads still to issue after the next one

    // Read pipeline and skid buffer
    logic                  infl;      // a read was issued last cycle
    logic                  infl_last; // that read was the frame's final read
    logic [1:0]            cnt;       // buffered entries (0..2)
    logic [ENT_W-1:0]      ent0;      // head entry {tdata, tdest, tlast}
    logic [ENT_W-1:0]      ent1;

    // Combinational helpers
    logic                  hi_found, lo_found, arb_found;
    logic [CH_W-1:0]       hi_ch, lo_ch, arb_ch;
    logic [AXIS_LEN_W-1:0] arb_len;
    logic                  cur_empty;
    logic [DATA_W-1:0]     cur_rdata;
    logic                  pop, rd, rd_last, slot_ok;
    logic [2:0]            occ;
    logic [ENT_W-1:0]      new_ent;

    // Round-robin pick: first non-empty channel above ptr, else first at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (!hi_found && (CH_W'(c) > ptr) && !fifo_empty_i[c]) begin
                hi_found = 1'b1;
                hi_ch    = CH_W'(c);
            end
            if (!lo_found && (CH_W'(c) <= ptr) && !fifo_empty_i[c]) begin
                lo_found = 1'b1;
                lo_ch    = CH_W'(c);
            end
        end
        arb_found = hi_found | lo_found;
        arb_ch    = hi_found ? hi_ch : lo_ch;
    end

    // Per-channel muxes: length of the candidate, empty/data of the open frame.
    always_comb begin
        arb_len   = '0;
        cur_empty = 1'b1;
        cur_rdata = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (CH_W'(c) == arb_ch) begin
                arb_len = len_i[c*AXIS_LEN_W +: AXIS_LEN_W];
            end
            if (CH_W'(c) == cur_ch) begin
                cur_empty = fifo_empty_i[c];
                cur_rdata = fifo_rdata_i[c*DATA_W +: DATA_W];
            end
        end
    end

    // A read is allowed only if the word it returns is guaranteed a buffer slot.
    assign pop     = cke_i & axis_tvalid_o & axis_tready_i;
    assign occ     = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
    assign slot_ok = (occ < 3'd2);
    assign rd      = cke_i & en_i & (state == ST_BURST) & ~cur_empty & slot_ok;
    assign rd_last = rd & (rem == '0);

    // Drive the read strobe of the open frame's channel only.
    always_comb begin
        fifo_read_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            fifo_read_o[c] = rd & (CH_W'(c) == cur_ch);
        end
    end

    // cur_ch only changes at the end of an ARB cycle, so a word returning
    // during ARB is still tagged with the frame that read it.
    assign new_ent = {cur_rdata, TDEST_W'(cur_ch), infl_last};

    // Frame FSM: latch channel and length in ARB, count reads in BURST.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state  <= ST_ARB;
            ptr    <= CH_W'(N_CH - 1);
            cur_ch <= '0;
            rem    <= '0;
        end else if (cke_i) begin
            case (state)
                ST_ARB: begin
                    if (en_i && arb_found) begin
                        cur_ch <= arb_ch;
                        rem    <= arb_len - LEN_ONE;  // 0 wraps to 2^W-1: a full-size frame
                        state  <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (rd) begin
                        if (rem == '0) begin
                            ptr   <= cur_ch;
                            state <= ST_ARB;
                        end else begin
                            rem <= rem - LEN_ONE;
                        end
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // Track the read issued last cycle; its data arrives this cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            infl      <= 1'b0;
            infl_last <= 1'b0;
        end else if (cke_i) begin
            infl      <= rd;
            infl_last <= rd_last;
        end
    end

    // Two-entry skid buffer: head in ent0, simultaneous push and pop allowed.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (cke_i) begin
            case ({infl, pop})
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        ent0 <= new_ent;
                    end else begin
                        ent1 <= new_ent;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        ent0 <= new_ent;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    assign axis_tvalid_o = (cnt != 2'd0);
    assign axis_tdata_o  = ent0[ENT_W-1 -: DATA_W];
    assign axis_tdest_o  = ent0[TDEST_W:1];
    assign axis_tlast_o  = ent0[0];
    assign busy_o        = (state == ST_BURST) | (cnt != 2'd0) | infl;

`ifdef FIFO2AXIS_MC_FRAME_CNT_EN
    logic [15:0] frame_cnt [N_CH];

    // Count a completed frame whenever a tlast word is accepted downstream.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int c = 0; c < N_CH; c++) begin
                frame_cnt[c] <= '0;
            end
        end else if (pop && axis_tlast_o) begin
            for (int c = 0; c < N_CH; c++) begin
                if (axis_tdest_o == TDEST_W'(c)) begin
                    frame_cnt[c] <= frame_cnt[c] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        frame_cnt_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            frame_cnt_o[c*16 +: 16] = frame_cnt[c];
        end
    end
`endif

endmodule

// File: tb/tb_fifo2axis_mc.sv
// Bench for fifo2axis_mc: FIFO models per channel, expected-word scoreboard
// built from frame rules (round-robin order, per-channel length, tlast on the
// final word), plus per-cycle protocol checks.
module tb_fifo2axis_mc;
  localparam int N_CH       = 2;
  localparam int DATA_W     = 32;
  localparam int AXIS_LEN_W = 4;
  localparam int TDEST_W    = 1;
  localparam int ENT_W      = DATA_W + TDEST_W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic                       cke, en, axis_tready;
  logic [N_CH*AXIS_LEN_W-1:0] len;
  logic [N_CH-1:0]            fifo_empty, fifo_read;
  logic [N_CH*DATA_W-1:0]     fifo_rdata;
  logic                       axis_tvalid, axis_tlast, busy;
  logic [DATA_W-1:0]          axis_tdata;
  logic [TDEST_W-1:0]         axis_tdest;
`ifdef FIFO2AXIS_MC_FRAME_CNT_EN
  logic [N_CH*16-1:0]         frame_cnt;
`endif

  fifo2axis_mc #(
    .N_CH(N_CH), .DATA_W(DATA_W), .AXIS_LEN_W(AXIS_LEN_W), .TDEST_W(TDEST_W)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .en_i(en), .len_i(len),
    .fifo_empty_i(fifo_empty), .fifo_read_o(fifo_read), .fifo_rdata_i(fifo_rdata),
    .axis_tvalid_o(axis_tvalid), .axis_tdata_o(axis_tdata), .axis_tdest_o(axis_tdest),
    .axis_tlast_o(axis_tlast), .axis_tready_i(axis_tready), .busy_o(busy)
`ifdef FIFO2AXIS_MC_FRAME_CNT_EN
    , .frame_cnt_o(frame_cnt)
`endif
  );

  // bench state
  logic [DATA_W-1:0] fq    [N_CH][$];  // words currently inside each FIFO
  logic [DATA_W-1:0] src_q [N_CH][$];  // words generated but not yet fed
  logic [ENT_W-1:0]  exp_q [$];        // expected stream {data, dest, last}
  int                hs_cyc_q [$];     // cycle index of every accepted word
  int                model_fcnt [N_CH];
  int                cyc, n_checks, n_errors, outstanding, rdy_mode;
  logic              prev_stall;
  logic [ENT_W:0]    prev_out;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic upd_empty();
    for (int c = 0; c < N_CH; c++) fifo_empty[c] = (fq[c].size() == 0);
  endtask

  task automatic set_len(input int c, input int v);
    len[c*AXIS_LEN_W +: AXIS_LEN_W] = AXIS_LEN_W'(v);
  endtask

  // Generate one frame of random words for channel c (len 0 means 16 words).
  task automatic gen_frame(input int c, input int l);
    int n;
    logic [DATA_W-1:0] v;
    n = (l == 0) ? (1 << AXIS_LEN_W) : l;
    for (int k = 0; k < n; k++) begin
      v = $urandom();
      src_q[c].push_back(v);
      exp_q.push_back({v, TDEST_W'(c), (k == n - 1)});
    end
  endtask

  task automatic feed(input int c, input int k);
    for (int i = 0; i < k; i++)
      if (src_q[c].size() > 0) fq[c].push_back(src_q[c].pop_front());
    upd_empty();
  endtask

  task automatic check_fcnt(input string tag);
`ifdef FIFO2AXIS_MC_FRAME_CNT_EN
    for (int c = 0; c < N_CH; c++)
      check(tag, 64'(frame_cnt[c*16 +: 16]), 64'(model_fcnt[c]));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // One clock: sample at negedge, FIFO response and new inputs at posedge+1.
  task automatic step();
    logic [N_CH-1:0]  rd_seen;
    logic             hs;
    logic [ENT_W-1:0] e;
    @(negedge clk);
    hs      = axis_tvalid & axis_tready;
    rd_seen = fifo_read;
    if (prev_stall)
      check("hold", 64'({axis_tvalid, axis_tdata, axis_tdest, axis_tlast}), 64'(prev_out));
    prev_stall = axis_tvalid & ~axis_tready;
    prev_out   = {axis_tvalid, axis_tdata, axis_tdest, axis_tlast};
    check("rd_onehot", 64'($countones(rd_seen) <= 1), 64'(1));
    check("rd_when_empty", 64'(rd_seen & fifo_empty), 64'(0));
    if (rd_seen != '0) check("rd_slot", 64'((outstanding - int'(hs)) < 2), 64'(1));
    if (hs) begin
      hs_cyc_q.push_back(cyc);
      check("word_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word", 64'({axis_tdata, axis_tdest, axis_tlast}), 64'(e));
        if (e[0]) model_fcnt[e[1 +: TDEST_W]]++;
      end
      outstanding--;
    end
    outstanding += $countones(rd_seen);
    cyc++;
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++)
      if (rd_seen[c] && fq[c].size() > 0) fifo_rdata[c*DATA_W +: DATA_W] = fq[c].pop_front();
    upd_empty();
    case (rdy_mode)
      1: axis_tready = ~axis_tready;
      2: begin
        axis_tready = ($urandom_range(0, 3) != 0);
        en          = ($urandom_range(0, 4) != 0);
        cke         = axis_tready ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      default: ;
    endcase
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && n < max_cyc) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    repeat (3) step();
    check({tag, "_idle"}, 64'(busy), 64'(0));
    check_fcnt({tag, "_fcnt"});
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear at once.
  task automatic apply_reset();
    #2;
    arst_n = 1'b0;
    #1;
    check("rst_tvalid", 64'(axis_tvalid), 64'(0));
    check("rst_tdata", 64'(axis_tdata), 64'(0));
    check("rst_tdest", 64'(axis_tdest), 64'(0));
    check("rst_tlast", 64'(axis_tlast), 64'(0));
    check("rst_read", 64'(fifo_read), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
`ifdef FIFO2AXIS_MC_FRAME_CNT_EN
    check("rst_fcnt", 64'(frame_cnt), 64'(0));
`endif
    exp_q.delete();
    hs_cyc_q.delete();
    for (int c = 0; c < N_CH; c++) begin
      fq[c].delete();
      src_q[c].delete();
      model_fcnt[c] = 0;
    end
    outstanding = 0;
    prev_stall  = 1'b0;
    en          = 1'b0;
    cke         = 1'b1;
    rdy_mode    = 0;
    upd_empty();
    repeat (2) step();
    arst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, l0, l1;
    arst_n = 1'b0; cke = 1'b1; en = 1'b0; axis_tready = 1'b0;
    len = '0; fifo_empty = '1; fifo_rdata = '0;
    cyc = 0; n_checks = 0; n_errors = 0; outstanding = 0; rdy_mode = 0;
    prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < N_CH; c++) model_fcnt[c] = 0;

    // T1: single 4-word frame, latency 3 from en, one word per cycle
    apply_reset();
    set_len(0, 4); set_len(1, 4);
    gen_frame(0, 4); feed(0, 4);
    axis_tready = 1'b1;
    c0 = cyc;
    en = 1'b1;
    drain("t1", 100);
    check("t1_count", 64'(hs_cyc_q.size()), 64'(4));
    if (hs_cyc_q.size() == 4) begin
      check("t1_first_lat", 64'(hs_cyc_q[0] - c0), 64'(3));
      for (int i = 1; i < 4; i++) check("t1_rate", 64'(hs_cyc_q[i] - hs_cyc_q[i-1]), 64'(1));
    end

    // T2: both channels loaded, frames alternate with one bubble between
    apply_reset();
    set_len(0, 3); set_len(1, 2);
    gen_frame(0, 3); gen_frame(1, 2); gen_frame(0, 3); gen_frame(1, 2);
    feed(0, 6); feed(1, 4);
    axis_tready = 1'b1;
    en = 1'b1;
    drain("t2", 100);
    check("t2_count", 64'(hs_cyc_q.size()), 64'(10));
    if (hs_cyc_q.size() == 10)
      for (int i = 1; i < 10; i++)
        check("t2_gap", 64'(hs_cyc_q[i] - hs_cyc_q[i-1]), 64'((i == 3 || i == 5 || i == 8) ? 2 : 1));

    // T3: tready toggling during a 6-word frame
    apply_reset();
    set_len(0, 6);
    gen_frame(0, 6); feed(0, 6);
    axis_tready = 1'b1;
    rdy_mode = 1;
    en = 1'b1;
    drain("t3", 200);
    check("t3_count", 64'(hs_cyc_q.size()), 64'(6));
    rdy_mode = 0;

    // T4: ch0 starves mid-frame; ch1 must wait; mid-frame len change ignored
    apply_reset();
    set_len(0, 4); set_len(1, 2);
    gen_frame(0, 4); gen_frame(1, 2);
    feed(0, 2); feed(1, 2);
    axis_tready = 1'b1;
    en = 1'b1;
    repeat (12) step();
    check("t4_partial", 64'(hs_cyc_q.size()), 64'(2));
    check("t4_busy", 64'(busy), 64'(1));
    set_len(0, 7);
    feed(0, 2);
    drain("t4", 100);

    // T5: length field 0 gives a 16-word frame
    apply_reset();
    set_len(0, 0);
    gen_frame(0, 0); feed(0, 16);
    axis_tready = 1'b1;
    en = 1'b1;
    drain("t5", 100);
    check("t5_count", 64'(hs_cyc_q.size()), 64'(16));

    // T6: reset inside a ch1 frame, then arbitration restarts at ch0
    apply_reset();
    set_len(0, 2); set_len(1, 8);
    gen_frame(0, 2); gen_frame(1, 8);
    feed(0, 2); feed(1, 8);
    axis_tready = 1'b1;
    en = 1'b1;
    n = 0;
    while (exp_q.size() > 5 && n < 100) begin
      step();
      n++;
    end
    check("t6_progress", 64'(exp_q.size() <= 5), 64'(1));
    apply_reset();
    set_len(0, 2); set_len(1, 2);
    gen_frame(0, 2); gen_frame(1, 2);
    feed(0, 2); feed(1, 2);
    axis_tready = 1'b1;
    en = 1'b1;
    drain("t6", 100);

    // T7: random lengths, backpressure, enable and clock-enable gaps
    for (int ep = 0; ep < 3; ep++) begin
      apply_reset();
      l0 = $urandom_range(0, 15);
      l1 = $urandom_range(0, 15);
      set_len(0, l0); set_len(1, l1);
      for (int f = 0; f < 4; f++) begin
        gen_frame(0, l0);
        gen_frame(1, l1);
      end
      feed(0, src_q[0].size()); feed(1, src_q[1].size());
      axis_tready = 1'b1;
      en = 1'b1;
      rdy_mode = 2;
      drain("t7", 3000);
      rdy_mode = 0; axis_tready = 1'b1; en = 1'b1; cke = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
